// File: rtl/tnn_layer_sequencer.sv
// Streams one latched layer input vector bit-serially into a bank of popcount
// accumulators: clear pulse, one index per non-stalled cycle, then hold results.
module tnn_layer_sequencer #(
  parameter int TOTAL = 4,
  parameter int CNT_W = $clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TOTAL-1:0] in_data,
  input  logic             stall,
  output logic             acc_clr,
  output logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(TOTAL);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [TOTAL-1:0] data_q;
  logic             load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (load) data_q <= in_data;
    end
  end

  // cnt parks at TOTAL in DONE so accumulators gated by cnt<SIZE stay inert
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    acc_clr   = 1'b0;
    enable    = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        cnt_nxt  = '0;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        acc_clr   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        enable = !stall;
        if (!stall) begin
          if (cnt_q == LAST) begin
            cnt_nxt   = FULL;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        cnt_nxt   = FULL;
        if (out_ready) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Mux by comparison so the index bus may be wider than log2(TOTAL)
  always_comb begin
    sample = 1'b0;
    if (state == RUN) begin
      for (int i = 0; i < TOTAL; i++) begin
        if (cnt_q == CNT_W'(i)) sample = data_q[i];
      end
    end
  end

  assign cnt  = cnt_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tnn_layer_sequencer.sv
// Bench for tnn_layer_sequencer: vector table with stall/hold patterns, reset
// corner cases and a scoreboard fed by an attached SIZE=TOTAL popcount model.
module tb_tnn_layer_sequencer;

  localparam int TOTAL = 4;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int OW    = CNT_W + 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [TOTAL-1:0] in_data = '0;
  logic             stall = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, acc_clr, enable, sample, out_valid, busy;
  logic [CNT_W-1:0] cnt;

  int total = 0;
  int bad   = 0;

  tnn_layer_sequencer #(.TOTAL(TOTAL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .stall(stall), .acc_clr(acc_clr), .enable(enable),
    .cnt(cnt), .sample(sample), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TOTAL-1:0] data;
    int               stall_at;
    int               stall_len;
    bit               stall_clr;
    int               hold;
    int               exp_acc;
  } vec_t;

  vec_t vecs[6];

  logic [TOTAL-1:0] exp_q[$];
  int               acc = 0;
  logic [TOTAL-1:0] bits = '0;
  int               clr_seen = 0;
  int               pops = 0;
  logic             ov_prev = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack(input logic ir, input logic clr, input logic en,
                                         input logic [CNT_W-1:0] c, input logic s,
                                         input logic ov, input logic b);
    return {ir, clr, en, c, s, ov, b};
  endfunction

  function automatic logic [OW-1:0] outs();
    return {in_ready, acc_clr, enable, cnt, sample, out_valid, busy};
  endfunction

  // Popcount accumulator model attached to the DUT plus the scoreboard
  always @(negedge clk or posedge rst) begin
    logic [TOTAL-1:0] e;
    if (rst) begin
      exp_q.delete();
      acc      = 0;
      bits     = '0;
      clr_seen = 0;
      ov_prev  = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (acc_clr) begin
        acc  = 0;
        bits = '0;
        clr_seen++;
      end
      if (enable && int'(cnt) < TOTAL) begin
        acc = acc + int'(sample);
        bits[cnt[1:0]] = sample;
      end
      if (out_valid && !ov_prev) begin
        pops++;
        if (exp_q.size() == 0) begin
          check_output("sb_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("sb_acc", 32'(acc), 32'($countones(e)));
          check_output("sb_bits", 32'(bits), 32'(e));
          check_output("sb_clr_once", 32'(clr_seen), 32'd1);
        end
        clr_seen = 0;
      end
      ov_prev = out_valid;
    end
  end

  // Offer one vector, then walk every period of CLEAR/RUN/DONE against a timing model
  task automatic apply_stimulus(input vec_t v);
    int run_len;
    int last;
    int q;
    logic [CNT_W-1:0] ec;
    logic [OW-1:0] exp;
    run_len = TOTAL + v.stall_len;
    last    = run_len + 2 + v.hold;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = v.data;
    out_ready = 1'b0;
    stall     = 1'b0;
    @(negedge clk);
    check_output("idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int p = 1; p <= last; p++) begin
      in_data = TOTAL'($urandom);
      if (p == 1) stall = v.stall_clr;
      else stall = (p >= 2 + v.stall_at) && (p < 2 + v.stall_at + v.stall_len);
      out_ready = (p < run_len + 2) ? 1'($urandom_range(0, 1)) : (p == last);
      @(negedge clk);
      if (p == 1) begin
        exp = pack(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      end else if (p < run_len + 2) begin
        q = p - 2;
        if (q < v.stall_at) ec = CNT_W'(q);
        else if (q < v.stall_at + v.stall_len) ec = CNT_W'(v.stall_at);
        else ec = CNT_W'(q - v.stall_len);
        exp = pack(1'b0, 1'b0, !stall, ec, v.data[ec], 1'b0, 1'b1);
      end else begin
        exp = pack(1'b0, 1'b0, 1'b0, CNT_W'(TOTAL), 1'b0, 1'b1, 1'b1);
      end
      check_output($sformatf("period%0d", p), 32'(outs()), 32'(exp));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    stall     = 1'b0;
    @(negedge clk);
    check_output("back_to_idle", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0)));
    check_output("tbl_acc", 32'(acc), 32'(v.exp_acc));
  endtask

  initial begin
    int pops0;
    vec_t v1111;
    vecs[0] = '{4'b1011, 0, 0, 1'b0, 0, 3};
    vecs[1] = '{4'b1011, 1, 2, 1'b0, 0, 3};
    vecs[2] = '{4'b0110, 0, 0, 1'b0, 5, 2};
    vecs[3] = '{4'b0000, 0, 1, 1'b1, 0, 0};
    vecs[4] = '{4'b1000, 3, 3, 1'b0, 1, 1};
    vecs[5] = '{4'b1101, 2, 1, 1'b1, 2, 3};

    #12;
    check_output("in_reset", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0)));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("after_reset", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0)));
    @(posedge clk); #1;
    out_ready = 1'b1;
    stall     = 1'b1;
    @(negedge clk);
    check_output("idle_hold", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0)));

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    // Reset while cnt==2 abandons the sample
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 4'b1011;
    stall    = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1;
    check_output("pre_reset_cnt", 32'(cnt), 32'd2);
    rst = 1'b1;
    #1;
    check_output("async_reset", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0)));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("no_out_after_rst", 32'({out_valid, busy}), 32'd0);
    end
    v1111 = '{4'b1111, 0, 0, 1'b0, 0, 4};
    apply_stimulus(v1111);

    // in_valid held high with in_data changing every cycle
    pops0 = pops;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_data = TOTAL'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    @(negedge clk);
    check_output("drain_idle", 32'(busy), 32'd0);
    check_output("drain_queue", 32'(exp_q.size()), 32'd0);
    check_output("stream_count", 32'(pops - pops0 >= 3), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
